// File: rtl/uart_tx.sv
// UART transmitter with byte FIFO; 8N1 frames, even parity added when UART_TX_PARITY_EN is defined.
// Latency: write at edge N, pop at N+1, start bit on o_tx after N+1 when idle.
// Backpressure: none; writes to a full FIFO with no same-cycle pop are dropped and flagged on o_overflow.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] i_data,
    input  logic       i_data_en,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_fifo_full,
    output logic       o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        r_state;
    logic          r_tx;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_bit_end;
    logic w_wr_req;
    logic w_pop;
    logic w_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == COUNT_FULL);
    assign w_bit_end = (r_baud == BAUD_MAX);
    assign w_wr_req  = i_data_en && clk_en;
    // A pop happens on the same edge the FSM leaves IDLE or finishes STOP.
    assign w_pop     = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
    assign w_push    = w_wr_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_req && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= START;
                        r_shift <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_baud  <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        r_idx  <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= ^r_shift;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_tx <= r_shift[r_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                        r_baud  <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        // Chain straight into the next start bit when more bytes are queued.
                        if (!w_empty) begin
                            r_state <= START;
                            r_shift <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx        = r_tx;
    assign o_busy      = !w_empty || (r_state != IDLE);
    assign o_fifo_full = w_full;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; frame length follows UART_TX_PARITY_EN.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_data_en = 1'b0;
    logic       o_tx;
    logic       o_busy;
    logic       o_fifo_full;
    logic       o_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .i_data     (i_data),
        .i_data_en  (i_data_en),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_fifo_full(o_fifo_full),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called at the first cycle of the start bit; returns just after the frame's last cycle.
    task automatic check_frame(input string tag, input logic [7:0] d);
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("%s_bit%0d_c%0d", tag, b, c), o_tx, exp_bit(d, b));
                check($sformatf("%s_busy%0d_c%0d", tag, b, c), o_busy, 1);
                tick();
            end
        end
    endtask

    logic [7:0] ovf_bytes [6];
    int bad;

    initial begin
        ovf_bytes[0] = 8'h10; ovf_bytes[1] = 8'h21; ovf_bytes[2] = 8'h32;
        ovf_bytes[3] = 8'h43; ovf_bytes[4] = 8'h54; ovf_bytes[5] = 8'h65;

        // Reset state
        tick(); tick();
        check("rst_tx", o_tx, 1);
        check("rst_busy", o_busy, 0);
        check("rst_full", o_fifo_full, 0);
        check("rst_ovf", o_overflow, 0);
        rst = 1'b0;
        tick();

        // Single 0x55 and write-to-start latency
        i_data = 8'h55; i_data_en = 1'b1; tick(); i_data_en = 1'b0;
        check("lat_tx_n", o_tx, 1);
        check("lat_busy_n", o_busy, 1);
        tick();
        check_frame("f55", 8'h55);
        check("f55_busy_end", o_busy, 0);
        check("f55_tx_end", o_tx, 1);

        // Back-to-back frames
        i_data = 8'h41; i_data_en = 1'b1; tick();
        i_data = 8'h42; tick(); i_data_en = 1'b0;
        check_frame("f41", 8'h41);
        check_frame("f42", 8'h42);
        check("b2b_busy_end", o_busy, 0);

        // Overflow: six consecutive writes into a depth-4 FIFO
        i_data_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_data = ovf_bytes[i];
            tick();
        end
        i_data_en = 1'b0;
        check("ovf_flag", o_overflow, 1);
        check("ovf_full", o_fifo_full, 1);
        for (int i = 0; i < NBITS*CPB - 5; i++) tick();
        check("ovf_full_last", o_fifo_full, 1);
        tick();
        check("ovf_full_clr", o_fifo_full, 0);
        for (int i = 1; i < 5; i++) check_frame($sformatf("ovf%0d", i), ovf_bytes[i]);
        check("ovf_busy_end", o_busy, 0);
        check("ovf_tx_end", o_tx, 1);
        check("ovf_sticky", o_overflow, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("ovf_rst_clr", o_overflow, 0);
        tick();

        // clk_en low ignores the write
        clk_en = 1'b0; i_data = 8'h99; i_data_en = 1'b1; tick();
        i_data_en = 1'b0; clk_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
            tick();
        end
        check("clken_ignored", bad, 0);

        // Reset mid-frame during data bit 3 of 0xA5, with a byte queued and a write alongside reset
        i_data = 8'hA5; i_data_en = 1'b1; tick();
        i_data = 8'h3C; tick(); i_data_en = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        check("a5_bit3", o_tx, 0);
        rst = 1'b1; i_data = 8'hFF; i_data_en = 1'b1; tick();
        i_data_en = 1'b0;
        check("midrst_tx", o_tx, 1);
        check("midrst_busy", o_busy, 0);
        check("midrst_ovf", o_overflow, 0);
        check("midrst_full", o_fifo_full, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
        end
        check("midrst_quiet", bad, 0);

        // 0x07: odd number of ones, parity bit 1 when enabled
        i_data = 8'h07; i_data_en = 1'b1; tick(); i_data_en = 1'b0;
        tick();
        check_frame("f07", 8'h07);
        check("f07_busy_end", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: byte entries in the transmit FIFO; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  system clock; one clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port clk_en  input  1  qualifies i_data_en only; does not gate bit timing.
REQ-006 SHALL have port i_data  input  8  byte from the RAM UART write tap.
REQ-007 SHALL have port i_data_en  input  1  byte-write strobe, one cycle per byte.
REQ-008 SHALL have port o_tx  output  1  serial line, idle high.
REQ-009 SHALL have port o_busy  output  1  high while the FIFO is non-empty or a frame is in flight.
REQ-010 SHALL have port o_fifo_full  output  1  high when the FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port o_overflow  output  1  sticky: a byte was dropped.

Function
REQ-012 SHALL push i_data into the FIFO on a rising edge where i_data_en && clk_en && (!full || pop in same cycle).
REQ-013 SHALL drop a write arriving while full with no same-cycle pop, set o_overflow, and leave FIFO contents unchanged.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY (only when macro defined), STOP.
REQ-015 SHALL, in IDLE with FIFO non-empty, pop the head byte and enter START on that edge; o_tx low from the next cycle.
REQ-016 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a baud counter that reloads at each bit boundary.
REQ-017 SHALL send DATA bits LSB first, 8 bits, using a 3-bit index that wraps 7->0 on exit to the next state.
REQ-018 SHALL drive STOP high for one bit time, then enter START directly if the FIFO is non-empty (back-to-back frames, no idle gap), else IDLE.
REQ-019 SHALL make write-to-start-bit latency 2 cycles when the FIFO is empty and the FSM is IDLE: write at edge N, pop at N+1, o_tx low after N+1.
REQ-020 SHALL use read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, with a count of log2(FIFO_DEPTH)+1 bits; count unchanged on simultaneous push and pop.
REQ-021 SHALL drive o_fifo_full and o_busy combinationally from registered state, not from i_data_en.

Reset
REQ-022 SHALL on rst: FSM IDLE, o_tx=1, pointers/count=0, baud counter and bit index=0, o_overflow=0, o_busy=0, o_fifo_full=0.
REQ-023 SHALL abort a frame on rst mid-frame: o_tx high the cycle after the reset edge; queued bytes discarded.
REQ-024 SHALL give rst priority over a simultaneous write; that byte is lost without setting o_overflow.

Configuration
REQ-025 SHALL compile in an even-parity bit when macro UART_TX_PARITY_EN is defined: PARITY state between DATA and STOP, one bit time, value = XOR of the 8 data bits (11-bit frame).
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, have no PARITY state and send a 10-bit 8N1 frame.

Verification (bench CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 SHALL cover: single write 0x55 from reset, macro undefined -> o_tx low 2 cycles later, then 1,0,1,0,1,0,1,0,1 (data + stop), each 4 cycles; o_busy falls after 40 frame cycles.
REQ-028 SHALL cover: writes 0x41,0x42 on consecutive cycles -> two back-to-back frames, no idle gap, 80 cycles total.
REQ-029 SHALL cover: 6 writes on consecutive cycles -> 5 accepted (1 popped + 4 queued), 6th dropped, o_overflow=1, o_fifo_full=1 until first STOP-to-START pop.
REQ-030 SHALL cover: write with clk_en=0 -> ignored, o_tx stays 1, o_busy stays 0.
REQ-031 SHALL cover: rst asserted during DATA bit 3 of 0xA5 -> o_tx=1, o_busy=0 next cycle; no further frame.
REQ-032 SHALL cover: UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1, 11-bit frame of 44 cycles.
